// File: rtl/ram_cmd_initiator.sv
// Host-to-RAM command initiator: turns single read/write requests into paced
// {cmd, payload} pulses on din/rx_valid, skips reloading addresses, times out reads.
module ram_cmd_initiator #(
  parameter int CMD_GAP    = 2,
  parameter int TIMEOUT    = 16,
  parameter int ADDR_CACHE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [9:0] din,
  output logic       rx_valid,
  input  logic [7:0] dout,
  input  logic       tx_valid,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  localparam int GW = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CMD_WA = 2'b00;
  localparam logic [1:0] CMD_WD = 2'b01;
  localparam logic [1:0] CMD_RA = 2'b10;
  localparam logic [1:0] CMD_RD = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_GAP, S_WAIT_RD} state_t;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  state_t        state, state_nxt, ret, ret_nxt;
  req_t          cur, req_in, eff;
  logic [GW-1:0] gap_cnt, gap_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic [9:0]    din_nxt;
  logic          accept, hit, rd_done, rd_to;
  logic          wr_vld, rd_vld;
  logic [7:0]    wr_addr, rd_addr;

  assign req_in    = {req_write, req_addr, req_wdata};
  // Requests are taken straight from the ports on the accept cycle.
  assign eff       = (state == S_IDLE) ? req_in : cur;
  assign req_ready = (state == S_IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  assign rx_valid  = (state == S_ADDR) | (state == S_DATA);

  always_comb begin
    hit = 1'b0;
    if (ADDR_CACHE != 0)
      hit = req_write ? (wr_vld && wr_addr == req_addr) : (rd_vld && rd_addr == req_addr);
  end

  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret;
    gap_cnt_nxt = gap_cnt;
    to_cnt_nxt  = to_cnt;
    rd_done     = 1'b0;
    rd_to       = 1'b0;
    din_nxt     = din;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = hit ? S_DATA : S_ADDR;
      end
      S_ADDR: begin
        ret_nxt     = S_DATA;
        gap_cnt_nxt = '0;
        state_nxt   = (CMD_GAP == 0) ? S_DATA : S_GAP;
      end
      S_DATA: begin
        if (cur.write) begin
          ret_nxt     = S_IDLE;
          gap_cnt_nxt = '0;
          state_nxt   = (CMD_GAP == 0) ? S_IDLE : S_GAP;
        end else begin
          to_cnt_nxt = '0;
          state_nxt  = S_WAIT_RD;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(CMD_GAP - 1)) state_nxt = ret;
        else gap_cnt_nxt = gap_cnt + 1'b1;
      end
      S_WAIT_RD: begin
        // The 11 pulse refreshes dout, so any tx_valid seen here is current.
        if (tx_valid) begin
          rd_done   = 1'b1;
          state_nxt = S_IDLE;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          rd_to     = 1'b1;
          state_nxt = S_IDLE;
        end else if (to_cnt != {TW{1'b1}}) begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (state_nxt == S_ADDR)
      din_nxt = {eff.write ? CMD_WA : CMD_RA, eff.addr};
    else if (state_nxt == S_DATA)
      din_nxt = eff.write ? {CMD_WD, eff.wdata} : {CMD_RD, 8'h00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ret       <= S_IDLE;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      cur       <= '0;
      din       <= '0;
      wr_vld    <= 1'b0;
      wr_addr   <= '0;
      rd_vld    <= 1'b0;
      rd_addr   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ret     <= ret_nxt;
      gap_cnt <= gap_cnt_nxt;
      to_cnt  <= to_cnt_nxt;
      din     <= din_nxt;
      if (accept) cur <= req_in;
      if (state == S_ADDR) begin
        if (cur.write) begin
          wr_vld  <= 1'b1;
          wr_addr <= cur.addr;
        end else begin
          rd_vld  <= 1'b1;
          rd_addr <= cur.addr;
        end
      end
      // A lost read leaves the RAM's read address in doubt.
      if (rd_to) rd_vld <= 1'b0;
      rsp_valid <= rd_done | rd_to;
      if (rd_done) begin
        rsp_data <= dout;
        rsp_err  <= 1'b0;
      end else if (rd_to) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule
